// File: rtl/adau_init_sequencer.sv
// rtl/adau_init_sequencer.sv - walks an ADAU1761 init table and feeds SPI write words to the SPI master
module adau_init_sequencer #(
    parameter int          ADDR_W       = 6,
    parameter int          DUMMY_WRITES = 3,
    parameter logic [31:0] DUMMY_WORD   = 32'h0040_0000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic [31:0]       spi_data,
    output logic              spi_valid,
    input  logic              spi_ready,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_DUMMY   = 4'd1;
    localparam logic [3:0] S_FETCH   = 4'd2;
    localparam logic [3:0] S_ROMWAIT = 4'd3;
    localparam logic [3:0] S_DECODE  = 4'd4;
    localparam logic [3:0] S_SEND    = 4'd5;
    localparam logic [3:0] S_DWAIT   = 4'd6;
    localparam logic [3:0] S_DELAY   = 4'd7;
    localparam logic [3:0] S_FLUSH   = 4'd8;
    localparam logic [3:0] S_DONE    = 4'd9;

    localparam logic [7:0] OP_WRITE = 8'h00;
    localparam logic [7:0] OP_DELAY = 8'h01;
    localparam logic [7:0] OP_END   = 8'hFF;

    localparam int            DCW        = (DUMMY_WRITES < 2) ? 1 : $clog2(DUMMY_WRITES + 1);
    localparam logic [DCW-1:0] DUMMY_LAST = DCW'(DUMMY_WRITES - 1);

    logic [3:0]     state;
    logic [DCW-1:0] dummy_cnt;
    logic [23:0]    delay_cnt;
    logic           at_last;

    // Advancing from the last table slot without an END entry is an overrun.
    assign at_last = (rom_addr == {ADDR_W{1'b1}});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            rom_addr  <= '0;
            spi_data  <= '0;
            spi_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            dummy_cnt <= '0;
            delay_cnt <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        rom_addr  <= '0;
                        dummy_cnt <= '0;
                        if (DUMMY_WRITES == 0) begin
                            state <= S_FETCH;
                        end else begin
                            state     <= S_DUMMY;
                            spi_data  <= DUMMY_WORD;
                            spi_valid <= 1'b1;
                        end
                    end
                end
                S_DUMMY: begin
                    if (spi_ready) begin
                        dummy_cnt <= dummy_cnt + 1'b1;
                        if (dummy_cnt == DUMMY_LAST) begin
                            spi_valid <= 1'b0;
                            state     <= S_FETCH;
                        end
                    end
                end
                S_FETCH:   state <= S_ROMWAIT;
                S_ROMWAIT: state <= S_DECODE;
                S_DECODE: begin
                    case (rom_data[31:24])
                        OP_WRITE: begin
                            spi_data  <= {8'h00, rom_data[23:0]};
                            spi_valid <= 1'b1;
                            state     <= S_SEND;
                        end
                        OP_DELAY: begin
                            delay_cnt <= rom_data[23:0];
                            state     <= S_DWAIT;
                        end
                        OP_END:  state <= S_FLUSH;
                        default: begin
                            error <= 1'b1;
                            state <= S_FLUSH;
                        end
                    endcase
                end
                S_SEND: begin
                    if (spi_ready) begin
                        spi_valid <= 1'b0;
                        if (at_last) begin
                            error <= 1'b1;
                            state <= S_FLUSH;
                        end else begin
                            rom_addr <= rom_addr + 1'b1;
                            state    <= S_FETCH;
                        end
                    end
                end
                S_DWAIT: begin
                    // Delay starts only once the previous word is fully shifted and latched.
                    if (spi_ready) begin
                        if (delay_cnt != 24'd0) begin
                            state <= S_DELAY;
                        end else if (at_last) begin
                            error <= 1'b1;
                            state <= S_FLUSH;
                        end else begin
                            rom_addr <= rom_addr + 1'b1;
                            state    <= S_FETCH;
                        end
                    end
                end
                S_DELAY: begin
                    delay_cnt <= delay_cnt - 1'b1;
                    if (delay_cnt == 24'd1) begin
                        if (at_last) begin
                            error <= 1'b1;
                            state <= S_FLUSH;
                        end else begin
                            rom_addr <= rom_addr + 1'b1;
                            state    <= S_FETCH;
                        end
                    end
                end
                S_FLUSH: begin
                    spi_valid <= 1'b0;
                    if (spi_ready) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
